barrel_shifter: RTL and testbench



---
 rtl/barrel_shifter_if.sv | 17 +
 rtl/barrel_shifter.sv | 38 +++
 tb/tb_barrel_shifter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/barrel_shifter_if.sv
// barrel_shifter_if: valid-qualified request/result bundle for the barrel shifter.
// master drives the request and observes the result; slave is the shifter side.
interface barrel_shifter_if #(
    parameter int WIDTH   = 8,
    parameter int SHIFT_W = $clog2(WIDTH)
);
    logic               in_valid;
    logic [WIDTH-1:0]   d_in;
    logic [SHIFT_W-1:0] n_bits;
    logic               dir;
    logic [1:0]         mode;
    logic [WIDTH-1:0]   d_out;
    logic               out_valid;

    modport master (output in_valid, d_in, n_bits, dir, mode, input d_out, out_valid);
    modport slave  (input in_valid, d_in, n_bits, dir, mode, output d_out, out_valid);
endinterface

// File: rtl/barrel_shifter.sv
// barrel_shifter: one-stage registered rotate/logical/arithmetic shifter, left or right.
// Stage i of the mux network moves the word by 2^i when n_bits[i] is set.
module barrel_shifter #(
    parameter int WIDTH   = 8,
    parameter int SHIFT_W = $clog2(WIDTH)
) (
    input logic            clk,
    input logic            rst_n,
    barrel_shifter_if.slave bus
);
    logic [SHIFT_W:0][WIDTH-1:0] stg;
    logic rot, arith;

    assign rot   = bus.mode == 2'b00;
    assign arith = bus.mode == 2'b10;
    assign stg[0] = bus.d_in;

    for (genvar g = 0; g < SHIFT_W; g++) begin : g_stage
        localparam int K = 1 << g;
        logic [WIDTH-1:0] lft, rgt;
        // The sign bit survives every right stage, so each stage can refill from its own MSB.
        always_comb begin
            lft = {stg[g][WIDTH-1-K:0], rot ? stg[g][WIDTH-1:WIDTH-K] : {K{1'b0}}};
            rgt = {rot ? stg[g][K-1:0] : {K{arith & stg[g][WIDTH-1]}}, stg[g][WIDTH-1:K]};
        end
        assign stg[g+1] = bus.n_bits[g] ? (bus.dir ? rgt : lft) : stg[g];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.d_out     <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) bus.d_out <= stg[SHIFT_W];
        end
    end
endmodule

// File: tb/tb_barrel_shifter.sv
// tb_barrel_shifter: directed vector table, flow/reset sequences and random
// stimulus checked against an arithmetic reference model.
module tb_barrel_shifter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int fails = 0;
    logic [7:0] held;

    barrel_shifter_if #(.WIDTH(8)) bus ();
    barrel_shifter #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic [2:0] n;
        logic       dr;
        logic [1:0] m;
        logic [7:0] exp;
    } vec_t;

    function automatic logic [7:0] model(input logic [7:0] d, input int n, input logic dr, input logic [1:0] m);
        int x = d;
        if (m == 2'b00)
            return dr ? 8'(((x >> n) | (x << (8 - n))) & 255) : 8'(((x << n) | (x >> (8 - n))) & 255);
        if (m == 2'b10 && dr)
            return 8'((x - (d[7] ? 256 : 0)) >>> n);
        return dr ? 8'(x >> n) : 8'((x << n) & 255);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic [2:0] n, input logic dr, input logic [1:0] m);
        @(negedge clk);
        bus.in_valid = v;
        bus.d_in     = d;
        bus.n_bits   = n;
        bus.dir      = dr;
        bus.mode     = m;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back('{8'h39, 3'd5, 1'b0, 2'b00, 8'h27});
        vecs.push_back('{8'h39, 3'd2, 1'b1, 2'b00, 8'h4E});
        vecs.push_back('{8'h45, 3'd1, 1'b0, 2'b00, 8'h8A});
        vecs.push_back('{8'h39, 3'd3, 1'b0, 2'b01, 8'hC8});
        vecs.push_back('{8'h39, 3'd3, 1'b1, 2'b01, 8'h07});
        vecs.push_back('{8'h39, 3'd3, 1'b0, 2'b11, 8'hC8});
        vecs.push_back('{8'h39, 3'd3, 1'b1, 2'b11, 8'h07});
        vecs.push_back('{8'h45, 3'd4, 1'b1, 2'b10, 8'h04});
        vecs.push_back('{8'hC5, 3'd2, 1'b1, 2'b10, 8'hF1});
        vecs.push_back('{8'h80, 3'd7, 1'b1, 2'b10, 8'hFF});
        vecs.push_back('{8'h80, 3'd7, 1'b1, 2'b01, 8'h01});
        vecs.push_back('{8'h39, 3'd7, 1'b0, 2'b00, 8'h9C});
        vecs.push_back('{8'h39, 3'd1, 1'b1, 2'b00, 8'h9C});
        vecs.push_back('{8'h39, 3'd3, 1'b0, 2'b10, 8'hC8});
        vecs.push_back('{8'h45, 3'd7, 1'b1, 2'b10, 8'h00});
        for (int i = 0; i < 8; i++)
            vecs.push_back('{8'hA5, 3'd0, i[0], i[2:1], 8'hA5});

        bus.in_valid = 1'b0;
        bus.d_in = '0;
        bus.n_bits = '0;
        bus.dir = 1'b0;
        bus.mode = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_d_out", 32'(bus.d_out), 32'h0);
        chk("reset_out_valid", 32'(bus.out_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].d, vecs[i].n, vecs[i].dr, vecs[i].m);
            chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'h1);
            chk($sformatf("vec%0d_d_out", i), 32'(bus.d_out), 32'(vecs[i].exp));
        end

        drive(1'b0, 8'h12, 3'd3, 1'b0, 2'b01);
        chk("idle_valid", 32'(bus.out_valid), 32'h0);
        chk("idle_hold", 32'(bus.d_out), 32'hA5);

        drive(1'b1, 8'h39, 3'd5, 1'b0, 2'b00);
        chk("pre_reset_d_out", 32'(bus.d_out), 32'h27);
        @(negedge clk);
        bus.d_in = 8'h45;
        bus.n_bits = 3'd1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_d_out", 32'(bus.d_out), 32'h0);
        chk("async_reset_valid", 32'(bus.out_valid), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("post_reset_valid", 32'(bus.out_valid), 32'h0);
        chk("post_reset_d_out", 32'(bus.d_out), 32'h0);

        held = 8'h00;
        for (int i = 0; i < 300; i++) begin
            logic v;
            logic [7:0] d;
            logic [2:0] n;
            logic dr;
            logic [1:0] m;
            v = ($urandom_range(0, 3) != 0);
            d = 8'($urandom);
            n = 3'($urandom);
            dr = 1'($urandom);
            m = 2'($urandom);
            drive(v, d, n, dr, m);
            if (v) held = model(d, n, dr, m);
            chk($sformatf("rnd%0d_valid", i), 32'(bus.out_valid), 32'(v));
            chk($sformatf("rnd%0d_d_out", i), 32'(bus.d_out), 32'(held));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
